// File: rtl/cu_stream_cmd_splitter.sv
// Purpose: splits one (addr, count) descriptor into power-of-two, naturally aligned commands.
// Latency: first cmd_valid two cycles after start accept; then up to one command per cycle.
// Backpressure: cmd_* held while cmd_valid && !cmd_ready; issue stalls at MAX_OUTSTANDING.
// Option: CU_CMD_SPLIT_ROUNDUP_EN selects legacy tail round-up (over-fetch) sizing.
module cu_stream_cmd_splitter #(
  parameter int ELEM_BYTES_LOG2 = 2,
  parameter int MAX_CMD_BYTES   = 128,
  parameter int COUNT_WIDTH     = 32,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [COUNT_WIDTH-1:0] start_count,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic [11:0]            cmd_size,
  output logic                   cmd_last,
  input  logic                   rsp_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   rsp_error
);

  localparam int REM_W    = COUNT_WIDTH + ELEM_BYTES_LOG2;
  localparam int MAX_LOG2 = $clog2(MAX_CMD_BYTES);
  localparam int AL_W     = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    ~((ADDR_WIDTH'(1) << ELEM_BYTES_LOG2) - ADDR_WIDTH'(1));

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SET     = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_PENDING = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [REM_W-1:0]      rem_q;
  logic [11:0]           size_q;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      out_nxt;
  logic                  err_q;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [REM_W-1:0]      rem_nxt;

  // Command size from the low address bits (alignment) and the bytes still to move.
  // Only bits below log2(MAX_CMD_BYTES) can limit alignment; an address clear there
  // is aligned to the maximum command size.
  function automatic logic [11:0] calc_size(input logic [AL_W-1:0] a, input logic [REM_W-1:0] r);
    logic [11:0] align_sz;
    logic [11:0] fit_sz;
    align_sz = 12'(MAX_CMD_BYTES);
    for (int k = MAX_LOG2 - 1; k >= 0; k--) begin
      if (a[k]) align_sz = 12'(1) << k;
    end
`ifdef CU_CMD_SPLIT_ROUNDUP_EN
    // Smallest power of two covering the tail, capped at the maximum command.
    fit_sz = 12'(MAX_CMD_BYTES);
    for (int k = MAX_LOG2; k >= 0; k--) begin
      if (r <= (REM_W'(1) << k)) fit_sz = 12'(1) << k;
    end
`else
    // Largest power of two not exceeding the tail: never reads past the descriptor.
    fit_sz = 12'd1;
    for (int k = 0; k <= MAX_LOG2; k++) begin
      if (r >= (REM_W'(1) << k)) fit_sz = 12'(1) << k;
    end
`endif
    return (align_sz < fit_sz) ? align_sz : fit_sz;
  endfunction

  assign start_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign cmd_valid   = (state == S_REQ) && (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign cmd_addr    = addr_q;
  assign cmd_size    = size_q;
  assign cmd_last    = (state == S_REQ) && (REM_W'(size_q) >= rem_q);
  assign rsp_error   = err_q;
  assign issue       = cmd_valid && cmd_ready;
  assign addr_nxt    = addr_q + ADDR_WIDTH'(size_q);
  assign rem_nxt     = (rem_q > REM_W'(size_q)) ? (rem_q - REM_W'(size_q)) : '0;

  // Credit count: an issue and a response in the same cycle cancel out; a stray
  // response with nothing outstanding leaves the count at zero.
  always_comb begin
    out_nxt = outstanding;
    if (issue && !rsp_valid) begin
      out_nxt = outstanding + OUT_W'(1);
    end else if (!issue && rsp_valid && (outstanding != '0)) begin
      out_nxt = outstanding - OUT_W'(1);
    end
  end

  // Descriptor FSM, address/remaining bookkeeping and the registered next size.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      size_q      <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      if (rsp_valid && !issue && (outstanding == '0)) err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            addr_q <= start_addr & ADDR_MASK;
            rem_q  <= REM_W'(start_count) << ELEM_BYTES_LOG2;
            err_q  <= 1'b0;
            state  <= S_SET;
          end
        end
        S_SET: begin
          size_q <= calc_size(addr_q[AL_W-1:0], rem_q);
          state  <= (rem_q == '0) ? S_DONE : S_REQ;
        end
        S_REQ: begin
          if (issue) begin
            addr_q <= addr_nxt;
            rem_q  <= rem_nxt;
            size_q <= calc_size(addr_nxt[AL_W-1:0], rem_nxt);
            if (cmd_last) state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (out_nxt == '0) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cu_stream_cmd_splitter.sv
// Bench for cu_stream_cmd_splitter: descriptor table, hand-timed corner sequences
// and randomized descriptors against an arithmetic command-list model.
module tb_cu_stream_cmd_splitter;

  localparam int MAXO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_valid, start_ready;
  logic [63:0] start_addr;
  logic [31:0] start_count;
  logic        cmd_valid, cmd_ready, cmd_last;
  logic [63:0] cmd_addr;
  logic [11:0] cmd_size;
  logic        rsp_valid, busy, done, rsp_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] exp_a[$];
  int unsigned exp_s[$];
  logic [63:0] got_a[$];
  int unsigned got_s[$];

  typedef struct packed {
    logic [63:0]      addr;
    logic [31:0]      count;
    logic [2:0]       n;
    logic [3:0][63:0] ea;
    logic [3:0][11:0] es;
  } vec_t;

  always #5 clock = ~clock;

  cu_stream_cmd_splitter dut (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_count(start_count),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .busy(busy), .done(done), .rsp_error(rsp_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected command list straight from the sizing rules.
  task automatic model(input logic [63:0] a, input int unsigned cnt);
    longint unsigned ad, rem, al, fit, sz;
    exp_a.delete();
    exp_s.delete();
    ad  = a & ~64'h3;
    rem = longint'(cnt) * 4;
    while (rem > 0) begin
      al  = (ad % 128 == 0) ? 128 : (ad & (~ad + 1));
      fit = 1;
`ifdef CU_CMD_SPLIT_ROUNDUP_EN
      while (fit < rem) fit = fit * 2;
`else
      while (fit * 2 <= rem) fit = fit * 2;
`endif
      sz = 128;
      if (al < sz) sz = al;
      if (fit < sz) sz = fit;
      exp_a.push_back(ad);
      exp_s.push_back(int'(sz));
      ad  = ad + sz;
      rem = (sz >= rem) ? 0 : rem - sz;
    end
  endtask

  // Runs one descriptor to completion with random ready/response pacing.
  // Entered and left just after a falling edge.
  task automatic run_xfer(input logic [63:0] a, input int unsigned cnt,
                          input int rdy_pct, input int rsp_pct);
    int  pend, ncyc, n_iss, n_exp;
    bit  seen_done;
    logic rdy, rsp;
    model(a, cnt);
    n_exp = exp_a.size();
    got_a.delete();
    got_s.delete();
    pend = 0; n_iss = 0; ncyc = 0; seen_done = 0;
    while (!start_ready && ncyc < 100) begin
      @(negedge clock);
      ncyc++;
    end
    chk("start_ready_before_start", start_ready, 1);
    start_valid = 1; start_addr = a; start_count = cnt;
    cmd_ready = 0; rsp_valid = 0;
    @(negedge clock);
    start_valid = 0;
    chk("busy_after_accept", busy, 1);
    ncyc = 0;
    while (!seen_done && ncyc < 3000) begin
      if (done) begin
        seen_done = 1;
        chk("cmd_count", n_iss, n_exp);
        chk("pending_at_done", pend, 0);
      end else begin
        rdy = ($urandom_range(99) < rdy_pct);
        rsp = (pend > 0) && ($urandom_range(99) < rsp_pct);
        if (cmd_valid) chk("credit_bound", pend < MAXO, 1);
        if (cmd_valid && rdy) begin
          got_a.push_back(cmd_addr);
          got_s.push_back(cmd_size);
          if (exp_a.size() > 0) begin
            chk("cmd_addr", cmd_addr, exp_a[0]);
            chk("cmd_size", cmd_size, exp_s[0]);
            chk("cmd_last", cmd_last, exp_a.size() == 1);
            void'(exp_a.pop_front());
            void'(exp_s.pop_front());
          end
          n_iss++;
          if (!rsp) pend++;
        end else if (rsp) begin
          pend--;
        end
        cmd_ready = rdy;
        rsp_valid = rsp;
        @(negedge clock);
        ncyc++;
      end
    end
    cmd_ready = 0;
    rsp_valid = 0;
    if (!seen_done) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout: got no done expected done within 3000 cycles");
    end
    @(negedge clock);
    chk("start_ready_after_done", start_ready, 1);
  endtask

  initial begin
    vec_t vt[5];
    int   n, n2;
    vt[0] = '{addr: 64'h1000, count: 64, n: 2,
              ea: {64'h0, 64'h0, 64'h1080, 64'h1000}, es: {12'd0, 12'd0, 12'd128, 12'd128}};
`ifdef CU_CMD_SPLIT_ROUNDUP_EN
    vt[1] = '{addr: 64'h1010, count: 10, n: 2,
              ea: {64'h0, 64'h0, 64'h1020, 64'h1010}, es: {12'd0, 12'd0, 12'd32, 12'd16}};
`else
    vt[1] = '{addr: 64'h1010, count: 10, n: 3,
              ea: {64'h0, 64'h1030, 64'h1020, 64'h1010}, es: {12'd0, 12'd8, 12'd16, 12'd16}};
`endif
    vt[2] = '{addr: 64'h1004, count: 3, n: 2,
              ea: {64'h0, 64'h0, 64'h1008, 64'h1004}, es: {12'd0, 12'd0, 12'd8, 12'd4}};
    vt[3] = '{addr: 64'h2000, count: 1, n: 1,
              ea: {64'h0, 64'h0, 64'h0, 64'h2000}, es: {12'd0, 12'd0, 12'd0, 12'd4}};
    vt[4] = '{addr: 64'h3003, count: 48, n: 2,
              ea: {64'h0, 64'h0, 64'h3080, 64'h3000}, es: {12'd0, 12'd0, 12'd64, 12'd128}};

    start_valid = 0; start_addr = 0; start_count = 0; cmd_ready = 0; rsp_valid = 0;
    repeat (2) @(negedge clock);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_size", cmd_size, 0);
    chk("rst_cmd_last", cmd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rsp_error", rsp_error, 0);
    reset = 0;
    @(negedge clock);

    // Stray response while idle, then a zero-count descriptor clears it.
    rsp_valid = 1;
    @(negedge clock);
    rsp_valid = 0;
    chk("idle_rsp_error_set", rsp_error, 1);
    start_valid = 1; start_addr = 64'h40; start_count = 0;
    @(negedge clock);
    start_valid = 0;
    chk("zc_set_busy", busy, 1);
    chk("zc_rsp_error_cleared", rsp_error, 0);
    chk("zc_no_done_at_t1", done, 0);
    @(negedge clock);
    chk("zc_done_at_t2", done, 1);
    chk("zc_no_cmd", cmd_valid, 0);
    @(negedge clock);
    chk("zc_done_pulse", done, 0);
    chk("zc_ready_at_t3", start_ready, 1);

    for (int i = 0; i < 5; i++) begin
      run_xfer(vt[i].addr, vt[i].count, 100, 100);
      chk("tbl_n", got_a.size(), vt[i].n);
      for (int j = 0; j < int'(vt[i].n) && j < got_a.size(); j++) begin
        chk("tbl_addr", got_a[j], vt[i].ea[j]);
        chk("tbl_size", got_s[j], vt[i].es[j]);
      end
    end

    // Latency, backpressure hold, coincident response and done after last response.
    start_valid = 1; start_addr = 64'h1000; start_count = 64;
    @(negedge clock);
    start_valid = 0;
    chk("lat_t1_no_valid", cmd_valid, 0);
    @(negedge clock);
    chk("lat_t2_valid", cmd_valid, 1);
    chk("lat_addr", cmd_addr, 64'h1000);
    chk("lat_size", cmd_size, 128);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", cmd_valid, 1);
      chk("bp_addr", cmd_addr, 64'h1000);
      chk("bp_size", cmd_size, 128);
      chk("bp_last", cmd_last, 0);
    end
    cmd_ready = 1;
    @(negedge clock);
    chk("second_addr", cmd_addr, 64'h1080);
    chk("second_last", cmd_last, 1);
    rsp_valid = 1;
    @(negedge clock);
    cmd_ready = 0; rsp_valid = 0;
    chk("coinc_no_done", done, 0);
    chk("coinc_busy", busy, 1);
    @(negedge clock);
    chk("coinc_outstanding_kept", done, 0);
    rsp_valid = 1;
    @(negedge clock);
    rsp_valid = 0;
    chk("done_at_r1", done, 1);
    @(negedge clock);
    chk("coinc_ready", start_ready, 1);
    chk("coinc_no_error", rsp_error, 0);

    // Credit limit: 608 elements = 17 full commands + 256 bytes left.
    start_valid = 1; start_addr = 0; start_count = 608;
    @(negedge clock);
    start_valid = 0; cmd_ready = 1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (cmd_valid) n++;
      @(negedge clock);
    end
    chk("credit_issued", n, MAXO);
    chk("credit_stalled", cmd_valid, 0);
    n2 = 0;
    for (int k = 0; k < 10; k++) begin
      if (cmd_valid) n2++;
      rsp_valid = (k == 0);
      @(negedge clock);
    end
    rsp_valid = 0;
    chk("credit_one_more", n2, 1);
    cmd_ready = 0;
    // Asynchronous reset in REQ with 256 bytes remaining and 16 outstanding.
    #2 reset = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start_ready", start_ready, 1);
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_cmd_addr", cmd_addr, 0);
    chk("arst_cmd_size", cmd_size, 0);
    chk("arst_cmd_last", cmd_last, 0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    start_valid = 1; start_addr = 0; start_count = 1024;
    @(negedge clock);
    start_valid = 0; cmd_ready = 1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (cmd_valid) n++;
      @(negedge clock);
    end
    cmd_ready = 0;
    chk("post_reset_credits", n, MAXO);
    reset = 1;
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    run_xfer(64'h1000, 64, 100, 100);

    for (int i = 0; i < 40; i++) begin
      run_xfer({48'h0, 16'($urandom)}, $urandom_range(0, 100), 60, 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cu_stream_cmd_splitter.md
# cu_stream_cmd_splitter

Parametrised read/write stream command generator for the compute unit. It accepts one transfer descriptor (start address, element count) and emits a sequence of CAPI-legal commands. Every command is a power-of-two size, naturally aligned and no larger than the configured maximum. Outstanding commands are bounded by a credit counter. It sits between a CU stream FSM and the command arbiter, and replaces the single-shot round-up size calculation with exact, alignment-aware splitting.

## Interface
- ELEM_BYTES_LOG2, 2: log2 of element size in bytes (element = 4 B).
- MAX_CMD_BYTES, 128: largest command size; power of two, 1..128.
- COUNT_WIDTH, 32: width of element count.
- ADDR_WIDTH, 64: byte address width.
- MAX_OUTSTANDING, 16: maximum commands issued but not yet completed.
- clock  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_valid  in  1  descriptor valid.
- start_ready  out  1  high only in IDLE.
- start_addr  in  ADDR_WIDTH  byte address; low ELEM_BYTES_LOG2 bits are masked to zero.
- start_count  in  COUNT_WIDTH  number of elements.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  arbiter accepts the command.
- cmd_addr  out  ADDR_WIDTH  command byte address.
- cmd_size  out  12  command bytes, power of two.
- cmd_last  out  1  final command of the descriptor.
- rsp_valid  in  1  one command completed.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the transfer is complete.
- rsp_error  out  1  sticky: a response arrived with zero outstanding; cleared on start accept.

## Operation
- States: IDLE, SET, REQ, PENDING, DONE.
- IDLE → SET on start_valid && start_ready. Latch addr and remaining = start_count << ELEM_BYTES_LOG2, width COUNT_WIDTH+ELEM_BYTES_LOG2.
- SET computes the first size. remaining == 0 → DONE. Otherwise → REQ.
- Size = min(MAX_CMD_BYTES, align(addr), fit(remaining)).
  - align = lowest set bit of addr; addr bits [6:0] == 0 counts as unlimited.
  - fit = largest power of two ≤ remaining.
- REQ: cmd_valid = (outstanding < MAX_OUTSTANDING).
- On a cmd_valid && cmd_ready handshake:
  - addr += size; remaining -= size (saturate at 0); outstanding++.
  - The next size is registered in the same cycle.
- cmd_last = 1 when size ≥ remaining. After the last handshake → PENDING.
- PENDING → DONE when outstanding == 0. DONE asserts done for one cycle → IDLE.
- rsp_valid decrements outstanding.
  - rsp_valid together with an issue handshake in the same cycle: outstanding is unchanged.
  - rsp_valid with outstanding == 0: outstanding stays 0 and rsp_error is set.
- Reset, including mid-transfer: state IDLE, outstanding 0, all counters cleared, in-flight responses discarded.

## Timing
- Reset values: start_ready 1, cmd_valid 0, cmd_addr 0, cmd_size 0, cmd_last 0, busy 0, done 0, rsp_error 0.
- Start accepted at cycle T → SET at T+1 → first cmd_valid at T+2.
- Throughput: one command per cycle while cmd_ready = 1 and credits are available.
- Backpressure: cmd_addr, cmd_size and cmd_last are held stable while cmd_valid && !cmd_ready.
- Zero-count descriptor: done at T+2, start_ready again at T+3.
- After the last response at cycle R (in PENDING): done at R+1.

## Configuration
- CU_CMD_SPLIT_ROUNDUP_EN defined:
  - fit = smallest power of two ≥ remaining (capped by MAX_CMD_BYTES and alignment), i.e. tail over-fetch.
  - remaining saturates to 0.
  - This is the legacy rounding behaviour.
- Not defined: exact splitting, no bytes beyond the descriptor.

## Test plan
- addr 0x1000, count 64, defaults → 128@0x1000, then 128@0x1080 with cmd_last; done after 2 responses.
- addr 0x1010, count 10, macro off → 16@0x1010, 16@0x1020, 8@0x1030 (last). Macro on → 16@0x1010, 32@0x1020 (last).
- MAX_OUTSTANDING = 2, addr 0, count 128, no responses → exactly 2 commands, then cmd_valid stays 0. One rsp_valid → exactly one more command.
- count 0 → no cmd_valid; done at T+2. rsp_valid while idle → rsp_error = 1; the next start clears it.
- cmd_ready held low 5 cycles during REQ → cmd_addr and cmd_size stable. rsp_valid coincident with a handshake → outstanding unchanged.
- reset asserted mid-REQ (remaining 256) → outputs at reset values asynchronously. A new descriptor afterwards runs cleanly from outstanding 0.
